// File: rtl/match_game.sv
// Two-counter reaction game: up/down counters sweep MIN_VAL..MAX_VAL in opposite
// directions and a Stop rising edge freezes them to score a match over ROUNDS rounds.
module match_game #(
  parameter int WIDTH    = 3,
  parameter int MIN_VAL  = 1,
  parameter int MAX_VAL  = 5,
  parameter int TICK_DIV = 1,
  parameter int HOLD_CYC = 4,
  parameter int ROUNDS   = 4
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         Start,
  input  logic                         Stop,
  output logic [WIDTH-1:0]             UpCount,
  output logic [WIDTH-1:0]             DownCount,
  output logic                         CntEn,
  output logic                         Win,
  output logic                         Lose,
  output logic [$clog2(ROUNDS+1)-1:0]  Score,
  output logic [$clog2(ROUNDS+1)-1:0]  Round,
  output logic                         Done,
  output logic [1:0]                   State
);

  localparam int CW = $clog2(ROUNDS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [WIDTH-1:0] MINV     = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PRE_TC   = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0]    HOLD_TC  = HW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]    RND_LAST = CW'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  up_q, up_d;
  logic [WIDTH-1:0]  dn_q, dn_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [CW-1:0]     score_q, score_d;
  logic [CW-1:0]     round_q, round_d;
  logic              stop_q, stop_d;
  logic              cen_q, cen_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic              done_q, done_d;
  logic              stop_rise;

  assign stop_rise = Stop & ~stop_q;

  // Next-state and registered-output computation; Stop outranks a coincident tick.
  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    dn_d    = dn_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    score_d = score_q;
    round_d = round_q;
    stop_d  = Stop;
    cen_d   = cen_q;
    win_d   = win_q;
    lose_d  = lose_q;
    done_d  = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          score_d = '0;
          round_d = '0;
          up_d    = MINV;
          dn_d    = MAXV;
          pre_d   = '0;
          cen_d   = 1'b1;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (stop_rise) begin
          state_d = HOLD;
          cen_d   = 1'b0;
          hold_d  = '0;
          round_d = round_q + CW'(1);
          if (up_q == dn_q) begin
            win_d   = 1'b1;
            score_d = score_q + CW'(1);
          end else begin
            lose_d  = 1'b1;
          end
        end else if (pre_q == PRE_TC) begin
          pre_d = '0;
          up_d  = (up_q == MAXV) ? MINV : up_q + WIDTH'(1);
          dn_d  = (dn_q == MINV) ? MAXV : dn_q - WIDTH'(1);
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      HOLD: begin
        // Leaving HOLD restarts the prescaler so the next step is a full TICK_DIV away.
        if (hold_q == HOLD_TC) begin
          win_d  = 1'b0;
          lose_d = 1'b0;
          pre_d  = '0;
          if (round_q == RND_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            cen_d   = 1'b1;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      up_q    <= MINV;
      dn_q    <= MAXV;
      pre_q   <= '0;
      hold_q  <= '0;
      score_q <= '0;
      round_q <= '0;
      stop_q  <= 1'b0;
      cen_q   <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      score_q <= score_d;
      round_q <= round_d;
      stop_q  <= stop_d;
      cen_q   <= cen_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      done_q  <= done_d;
    end
  end

  assign UpCount   = up_q;
  assign DownCount = dn_q;
  assign CntEn     = cen_q;
  assign Win       = win_q;
  assign Lose      = lose_q;
  assign Score     = score_q;
  assign Round     = round_q;
  assign Done      = done_q;
  assign State     = state_q;

endmodule
